// File: rtl/pulse_to_level_stretcher.sv
// pulse_to_level_stretcher
// Turns single-cycle event strobes into fixed-width high levels separated
// by a guaranteed low gap. Events that arrive while a level or gap is in
// progress are queued in a saturating pending counter and replayed in order.
// A sticky overflow flag records any event that was dropped at saturation.

// Assertion-only companion: parameter legality and output invariants.
module pulse_to_level_stretcher_chk #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 3
) (
   input logic              clk,
   input logic              rst,
   input logic              level_o,
   input logic              busy_o,
   input logic [PEND_W-1:0] pending_o
);

   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("pulse_to_level_stretcher: HOLD_CYCLES must be at least 1");
   end

   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("pulse_to_level_stretcher: GAP_CYCLES must be at least 1");
   end

   if (PEND_W < 1) begin : g_bad_pend
      $error("pulse_to_level_stretcher: PEND_W must be at least 1");
   end

   // A high level can only be driven while the engine is active.
   a_level_implies_busy : assert property (
      @(posedge clk) disable iff (rst) level_o |-> busy_o
   );

   // The engine never returns to idle with work still queued.
   a_idle_queue_empty : assert property (
      @(posedge clk) disable iff (rst) !busy_o |-> (pending_o == {PEND_W{1'b0}})
   );

endmodule

module pulse_to_level_stretcher #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int PEND_W      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_i,
   input  logic              clear_i,
   output logic              level_o,
   output logic              busy_o,
   output logic [PEND_W-1:0] pending_o,
   output logic              overflow_o
);

   // The shared down-counter must hold the longer of the two phase lengths.
   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [PEND_W-1:0]  pend_nxt_s;
   logic               ovf_nxt_s;
   logic               ovf_set_s;
   logic               last_gap_s;
   logic               consume_s;
   logic               direct_s;
   logic               inc_s;

   // Classify this cycle's event: direct launch, queue increment or replay.
   always_comb begin
      last_gap_s = (state_r == ST_GAP) && (cnt_r == CNT_ZERO);
      // Queued work always takes priority over a fresh strobe at gap end.
      consume_s  = last_gap_s && (pending_o != PEND_ZERO);
      // A strobe launches straight into HIGH when nothing is in flight or
      // when it lands on the last gap cycle with an empty queue.
      direct_s   = pulse_i && ((state_r == ST_IDLE) ||
                               (last_gap_s && (pending_o == PEND_ZERO)));
      inc_s      = pulse_i && (state_r != ST_IDLE) && !direct_s;
   end

   // Next FSM state and phase counter.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (pulse_i) begin
               state_nxt_s = ST_HIGH;
               cnt_nxt_s   = HOLD_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         end
         ST_HIGH: begin
            if (cnt_r == CNT_ZERO) begin
               state_nxt_s = ST_GAP;
               cnt_nxt_s   = GAP_LOAD;
            end else begin
               state_nxt_s = ST_HIGH;
               cnt_nxt_s   = cnt_r - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_r != CNT_ZERO) begin
               state_nxt_s = ST_GAP;
               cnt_nxt_s   = cnt_r - CNT_ONE;
            end else if (consume_s || direct_s) begin
               // Next level starts on the very next edge, no idle bubble.
               state_nxt_s = ST_HIGH;
               cnt_nxt_s   = HOLD_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // Saturating pending counter and sticky overflow flag.
   always_comb begin
      pend_nxt_s = pending_o;
      ovf_set_s  = 1'b0;
      if (inc_s && !consume_s) begin
         if (pending_o == PEND_MAX) begin
            // Queue full: the event is dropped and remembered as overflow.
            pend_nxt_s = pending_o;
            ovf_set_s  = 1'b1;
         end else begin
            pend_nxt_s = pending_o + PEND_ONE;
            ovf_set_s  = 1'b0;
         end
      end else if (consume_s && !inc_s) begin
         pend_nxt_s = pending_o - PEND_ONE;
         ovf_set_s  = 1'b0;
      end else begin
         // Either idle or an increment cancelled by a simultaneous replay.
         pend_nxt_s = pending_o;
         ovf_set_s  = 1'b0;
      end

      // A new drop outranks a clear arriving in the same cycle.
      if (ovf_set_s) begin
         ovf_nxt_s = 1'b1;
      end else if (clear_i) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = overflow_o;
      end
   end

   // State, counter and all outputs registered; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         level_o    <= 1'b0;
         busy_o     <= 1'b0;
         pending_o  <= PEND_ZERO;
         overflow_o <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         level_o    <= (state_nxt_s == ST_HIGH);
         busy_o     <= (state_nxt_s != ST_IDLE);
         pending_o  <= pend_nxt_s;
         overflow_o <= ovf_nxt_s;
      end
   end

   pulse_to_level_stretcher_chk #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .PEND_W      (PEND_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .level_o   (level_o),
      .busy_o    (busy_o),
      .pending_o (pending_o)
   );

endmodule

// File: tb/tb_pulse_to_level_stretcher.sv
// Bench for pulse_to_level_stretcher: two instances (PEND_W=3 and PEND_W=2)
// share one stimulus stream; a time-based reference model checks both every
// cycle, a constant table checks the burst/direct-launch waveform, and short
// hand sequences cover reset, overflow and clear corners.
module tb_pulse_to_level_stretcher;

   localparam int H = 4;
   localparam int G = 2;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       pulse_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       lvl_a, busy_a, ovf_a;
   logic [2:0] pend_a;
   logic       lvl_b, busy_b, ovf_b;
   logic [1:0] pend_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pulse_to_level_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(3)) dut_a (
      .clk(clk), .rst(rst), .pulse_i(pulse_i), .clear_i(clear_i),
      .level_o(lvl_a), .busy_o(busy_a), .pending_o(pend_a), .overflow_o(ovf_a)
   );

   pulse_to_level_stretcher #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(2)) dut_b (
      .clk(clk), .rst(rst), .pulse_i(pulse_i), .clear_i(clear_i),
      .level_o(lvl_b), .busy_o(busy_b), .pending_o(pend_b), .overflow_o(ovf_b)
   );

   // ---------------- reference model (absolute-time windows) ----------------
   // Each level occupies cycles [start, start+H-1], its gap runs to 'fin'.
   int tnow = 0;
   int m_start[2];
   int m_fin[2];
   int m_p[2];
   int m_ov[2];
   int pmax[2] = '{7, 3};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_start[i] = -1000;
         m_fin[i]   = -1000;
         m_p[i]     = 0;
         m_ov[i]    = 0;
      end
   endtask

   // Apply the inputs sampled at the edge that ends cycle 'tnow'.
   task automatic model_edge(input bit p, input bit c);
      bit in_win, last, cons, direct, inc, set_ov;
      for (int i = 0; i < 2; i++) begin
         in_win = (tnow >= m_start[i]) && (tnow <= m_fin[i]);
         last   = in_win && (tnow == m_fin[i]);
         cons   = last && (m_p[i] > 0);
         direct = p && (!in_win || (last && m_p[i] == 0));
         inc    = p && in_win && !direct;
         set_ov = 1'b0;
         if (cons || direct) begin
            m_start[i] = tnow + 1;
            m_fin[i]   = tnow + H + G;
         end
         if (inc && !cons) begin
            if (m_p[i] == pmax[i]) set_ov = 1'b1;
            else m_p[i] = m_p[i] + 1;
         end else if (cons && !inc) begin
            m_p[i] = m_p[i] - 1;
         end
         if (set_ov) m_ov[i] = 1;
         else if (c) m_ov[i] = 0;
      end
      tnow = tnow + 1;
   endtask

   function automatic int exp_level(input int i);
      return ((tnow >= m_start[i]) && (tnow <= m_start[i] + H - 1)) ? 1 : 0;
   endfunction

   function automatic int exp_busy(input int i);
      return ((tnow >= m_start[i]) && (tnow <= m_fin[i])) ? 1 : 0;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_vec = n_vec + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic compare_all();
      check("model_level_a", int'(lvl_a),  exp_level(0));
      check("model_busy_a",  int'(busy_a), exp_busy(0));
      check("model_pend_a",  int'(pend_a), m_p[0]);
      check("model_ovf_a",   int'(ovf_a),  m_ov[0]);
      check("model_level_b", int'(lvl_b),  exp_level(1));
      check("model_busy_b",  int'(busy_b), exp_busy(1));
      check("model_pend_b",  int'(pend_b), m_p[1]);
      check("model_ovf_b",   int'(ovf_b),  m_ov[1]);
   endtask

   // One clock: drive inputs, take the edge, then check against the model.
   task automatic step(input bit p, input bit c);
      pulse_i = p;
      clear_i = c;
      @(posedge clk);
      if (rst) model_reset();
      else model_edge(p, c);
      #1;
      compare_all();
   endtask

   // ---------------- constant vector table ----------------
   typedef struct {
      bit p;
      bit l;
      bit b;
      int n;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit p, input bit l, input bit b, input int n);
      vec_t v;
      v.p = p; v.l = l; v.b = b; v.n = n;
      tbl.push_back(v);
   endtask

   // Hard stop in case anything stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit p_r, c_r;
      int rises, prev, highs;

      // Burst of three (edges 0..2), then a single event with a direct
      // launch on its last gap cycle. Row t gives outputs after edge t.
      add(1,1,1,0); add(1,1,1,1); add(1,1,1,2); add(0,1,1,2); add(0,0,1,2); add(0,0,1,2);
      repeat (4) add(0,1,1,1);
      repeat (2) add(0,0,1,1);
      repeat (4) add(0,1,1,0);
      repeat (2) add(0,0,1,0);
      add(0,0,0,0);
      add(1,1,1,0); repeat (3) add(0,1,1,0); repeat (2) add(0,0,1,0);
      add(1,1,1,0); repeat (3) add(0,1,1,0); repeat (2) add(0,0,1,0);
      add(0,0,0,0);

      model_reset();

      // --- async reset with pulse toggling ---
      #2 rst = 1'b1;
      #1;
      check("rst_async_level", int'(lvl_a), 0);
      check("rst_async_busy",  int'(busy_a), 0);
      check("rst_async_pend",  int'(pend_a), 0);
      check("rst_async_ovf",   int'(ovf_a), 0);
      for (int i = 0; i < 4; i++) step(i[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0);
      check("rst_release_level", int'(lvl_a), 0);
      check("rst_release_busy",  int'(busy_a), 0);

      // --- table-driven burst / direct launch on instance A ---
      foreach (tbl[k]) begin
         step(tbl[k].p, 1'b0);
         check("tbl_level", int'(lvl_a),  int'(tbl[k].l));
         check("tbl_busy",  int'(busy_a), int'(tbl[k].b));
         check("tbl_pend",  int'(pend_a), tbl[k].n);
      end

      // --- overflow on instance B: 1 launch + 5 pulses during activity ---
      rises = 0;
      prev  = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0);
         if (lvl_b && prev == 0) rises = rises + 1;
         prev = int'(lvl_b);
         if (i == 3) begin
            check("ovf_sat_pend", int'(pend_b), 3);
            check("ovf_not_yet",  int'(ovf_b), 0);
         end
         if (i == 4) begin
            check("ovf_set_pend", int'(pend_b), 3);
            check("ovf_set",      int'(ovf_b), 1);
         end
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0);
         if (lvl_b && prev == 0) rises = rises + 1;
         prev = int'(lvl_b);
      end
      check("ovf_level_count", rises, 4);
      check("ovf_sticky", int'(ovf_b), 1);
      step(1'b0, 1'b1);
      check("ovf_cleared", int'(ovf_b), 0);

      // --- set and clear in the same cycle: set wins ---
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      check("setclr_pre_ovf", int'(ovf_b), 0);
      step(1'b1, 1'b1);
      check("setclr_set_wins", int'(ovf_b), 1);
      step(1'b0, 1'b1);
      check("setclr_then_clear", int'(ovf_b), 0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0);

      // --- reset mid-HIGH with two events queued ---
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      check("midrst_pre_pend",  int'(pend_a), 2);
      check("midrst_pre_level", int'(lvl_a), 1);
      pulse_i = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("midrst_level", int'(lvl_a), 0);
      check("midrst_pend",  int'(pend_a), 0);
      check("midrst_busy",  int'(busy_a), 0);
      model_reset();
      step(1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         if (lvl_a || lvl_b) highs = highs + 1;
      end
      check("midrst_no_levels", highs, 0);

      // --- randomized traffic against the model ---
      for (int i = 0; i < 800; i++) begin
         p_r = ($urandom_range(0, 99) < 40);
         c_r = ($urandom_range(0, 99) < 6);
         rst = ($urandom_range(0, 199) == 0);
         step(p_r, c_r);
      end
      rst = 1'b0;
      step(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_to_level_stretcher.md
# pulse_to_level_stretcher

Converts single-cycle event pulses into clean, fixed-width output levels separated by a guaranteed low gap. This is the inverse of the team's level-to-pulse edge detector. It sits on the output side of the UART/peripheral path, where short internal strobes (byte received, frame error, TX done) must drive LEDs, GPIO or slow external logic. Events that arrive while an output level is in progress are queued in a saturating pending counter, so none are lost up to the counter limit.

## Interface
- HOLD_CYCLES, 4, number of clk cycles level_o stays high per event (≥1)
- GAP_CYCLES, 2, minimum number of low cycles between two consecutive high levels (≥1)
- PEND_W, 3, width of the pending-event counter; max queued = 2^PEND_W − 1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- pulse_i  input  1  event strobe; every cycle sampled high counts as one event
- clear_i  input  1  clears sticky overflow_o
- level_o  output  1  stretched level, registered
- busy_o  output  1  high whenever FSM is not IDLE, registered
- pending_o  output  PEND_W  events queued but not yet emitted
- overflow_o  output  1  sticky: an event was dropped because pending was saturated

## Operation
- Reset values: state IDLE, level_o 0, busy_o 0, pending_o 0, overflow_o 0, internal counter 0.
- FSM states: IDLE, HIGH, GAP. Down-counter width = $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).
- IDLE:
  - pulse_i=1 → HIGH with counter loaded to HOLD_CYCLES−1.
  - This event is launched directly and is not added to pending.
- HIGH:
  - level_o=1 for exactly HOLD_CYCLES cycles.
  - When the counter reaches 0 → GAP with counter loaded to GAP_CYCLES−1.
- GAP:
  - level_o=0 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle, if pending>0 → consume one from pending and go to HIGH.
  - Else, if pulse_i=1 on that same cycle → launch it directly to HIGH; pending is unchanged.
  - Else → IDLE.
- Pending update:
  - pulse_i=1 in HIGH or GAP → +1, except when it is the direct launch described above.
  - A consume in the same cycle as an increment → net unchanged.
- Saturation:
  - Increment with pending = 2^PEND_W−1 and no simultaneous consume → pending holds and overflow_o is set.
  - overflow_o stays set until clear_i=1.
  - If set and clear occur in the same cycle, set wins.
- GAP_CYCLES=0 and HOLD_CYCLES=0 are illegal; an elaboration-time assertion flags them.
- busy_o=1 in HIGH and GAP; 0 only in IDLE.

## Timing
- Latency: pulse_i sampled at edge N → level_o high from edge N+1.
- Each emitted level is exactly HOLD_CYCLES cycles wide. Back-to-back events have a period of HOLD_CYCLES+GAP_CYCLES.
- HOLD/GAP boundaries occur with no idle bubble between them.
- From GAP with work pending, the next HIGH starts at the edge after the last GAP cycle.
- rst assertion anywhere, including mid-HIGH, forces all outputs to their reset values immediately, without waiting for a clock edge. Queued events are discarded.
- pulse_i high for k consecutive cycles counts as k events. pulse_i is treated as synchronous to clk; synchronization is upstream.

## Test plan
1. Reset:
   - Stimulus: assert rst asynchronously with pulse_i toggling.
   - Required: level_o, busy_o, pending_o, overflow_o all 0. The first edge after rst release with pulse_i=0 keeps them 0.
2. Single event (HOLD=4, GAP=2):
   - Stimulus: pulse_i high one cycle at edge 0.
   - Required: level_o=1 on cycles 1–4 and 0 on cycles 5–6; busy_o=1 on cycles 1–6; IDLE from cycle 7; pending_o stays 0.
3. Burst:
   - Stimulus: pulse_i high at edges 0, 1, 2.
   - Required: pending_o goes 1 then 2. level_o high on cycles 1–4, 7–10 and 13–16. pending_o is 0 after cycle 12.
4. Direct launch at gap end:
   - Stimulus: single event, then pulse_i on the last GAP cycle (edge 6).
   - Required: level_o high on 7–10 with no IDLE cycle; pending_o never leaves 0.
5. Overflow (PEND_W=2):
   - Stimulus: 1 launching pulse followed by 5 pulses during HIGH.
   - Required: pending_o saturates at 3 and overflow_o=1. Exactly 4 high levels are emitted in total. overflow_o clears only on the cycle after clear_i.
6. Reset mid-operation:
   - Stimulus: assert rst during cycle 2 of HIGH with pending_o=2.
   - Required: level_o=0 and pending_o=0 immediately. No further levels are emitted after rst releases.
